// File: rtl/ls194_ctrl_pkg.sv
//------------------------------------------------------------------------------
// ls194_ctrl_pkg : state encoding and LS194 mode-pin constants
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ls194_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // {S1,S0} encodings of the LS194
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

`default_nettype wire

// File: rtl/sn74ls194.sv
//------------------------------------------------------------------------------
// sn74ls194 : 4-bit universal shift register (behavioural model of the part)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sn74ls194 (
  input  logic CLK,
  input  logic CLR_n,
  input  logic S1,
  input  logic S0,
  input  logic SR,
  input  logic SL,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic QA,
  output logic QB,
  output logic QC,
  output logic QD
);

  logic [3:0] reg_q;
  logic [3:0] reg_d;

  // reg_q[3] is QA; right shift moves QA toward QD
  always_comb begin
    reg_d = reg_q;
    case ({S1, S0})
      2'b01:   reg_d = {SR, reg_q[3:1]};
      2'b10:   reg_d = {reg_q[2:0], SL};
      2'b11:   reg_d = {A, B, C, D};
      default: reg_d = reg_q;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) reg_q <= 4'b0000;
    else        reg_q <= reg_d;
  end

  assign {QA, QB, QC, QD} = reg_q;

endmodule

`default_nettype wire

// File: rtl/ls194_shift_ctrl.sv
//------------------------------------------------------------------------------
// ls194_shift_ctrl : TX/RX sequencer for a cascade of SN74LS194 registers
// Optional: LS194_CTRL_ROTATE_EN makes TX shifts rotate instead of zero-fill
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ls194_shift_ctrl
  import ls194_ctrl_pkg::*;
#(
  parameter int NCHIP = 1,
  parameter int LW    = $clog2(4*NCHIP+1)
) (
  input  logic               clk,
  input  logic               CR,
  input  logic               start,
  input  logic               op,
  input  logic               dir,
  input  logic [LW-1:0]      len,
  input  logic [4*NCHIP-1:0] tx_data,
  input  logic               pause,
  input  logic               sin,
  input  logic [4*NCHIP-1:0] q,
  output logic               S1,
  output logic               S0,
  output logic               SR,
  output logic               SL,
  output logic [4*NCHIP-1:0] par,
  output logic               clr_n,
  output logic               busy,
  output logic               done,
  output logic               sout,
  output logic               sout_valid,
  output logic [4*NCHIP-1:0] rx_data
);

  localparam int            W   = 4*NCHIP;
  localparam logic [LW-1:0] W_L = LW'(W);

  state_t          state_q, state_d;
  logic [LW-1:0]   cnt_q,   cnt_d;
  logic [LW-1:0]   len_q,   len_d;
  logic            op_q,    op_d;
  logic            dir_q,   dir_d;
  logic [W-1:0]    tx_q,    tx_d;
  logic [W-1:0]    rx_q,    rx_d;
  logic [1:0]      mode;
  logic            tx_feed;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    op_d    = op_q;
    dir_d   = dir_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          dir_d   = dir;
          len_d   = (len > W_L) ? W_L : len;
          tx_d    = tx_data;
          state_d = op ? ST_CLEAR : ST_LOAD;
        end
      end
      ST_CLEAR, ST_LOAD: begin
        cnt_d   = len_q;
        state_d = (len_q == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!pause) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (op_q) rx_d = q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge CR) begin
    if (!CR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      op_q    <= 1'b0;
      dir_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  assign sout = dir_q ? q[W-1] : q[0];

`ifdef LS194_CTRL_ROTATE_EN
  assign tx_feed = sout;
`else
  assign tx_feed = 1'b0;
`endif

  // clr_n is gated by CR directly so the datapath clears for the whole reset
  always_comb begin
    mode       = MODE_HOLD;
    clr_n      = CR;
    SR         = 1'b0;
    SL         = 1'b0;
    sout_valid = 1'b0;
    case (state_q)
      ST_CLEAR: clr_n = 1'b0;
      ST_LOAD:  mode  = MODE_LOAD;
      ST_SHIFT: begin
        if (!pause) begin
          mode       = dir_q ? MODE_SHL : MODE_SHR;
          sout_valid = !op_q;
        end
        if (op_q) begin
          SR = sin;
          SL = sin;
        end else begin
          SR = dir_q ? 1'b0 : tx_feed;
          SL = dir_q ? tx_feed : 1'b0;
        end
      end
      default: mode = MODE_HOLD;
    endcase
  end

  assign {S1, S0} = mode;
  assign par      = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign rx_data  = rx_q;

endmodule

`default_nettype wire
